pipe_mem: RTL and testbench

PIPE_MEM -- requirements
Module: pipe_mem

---
 rtl/pipe_mem_pkg.sv | 25 ++
 rtl/pipe_mem_mem_wb_reg.sv | 16 +
 rtl/pipe_mem.sv | 69 ++++++
 tb/tb_pipe_mem.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipe_mem_pkg.sv
// pipe_mem_pkg: shared CPU constants and pipeline-register bundles for the MEM stage.
package pipe_mem_pkg;

    localparam int DEF_DMEM_AW    = 6;
    localparam int DEF_DMEM_DEPTH = 2 ** DEF_DMEM_AW;
    localparam int WORD_OFS       = 2;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  wn;
        logic [31:0] alu;
        logic [31:0] di;
    } ex_mem_t;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [4:0]  wn;
        logic [31:0] alu;
        logic [31:0] mo;
    } mem_wb_t;

endpackage

// File: rtl/pipe_mem_mem_wb_reg.sv
// MEM_WB_reg: MEM/WB pipeline register, cleared asynchronously by clrn.
module MEM_WB_reg
    import pipe_mem_pkg::*;
(
    input  logic    clk,
    input  logic    clrn,
    input  mem_wb_t d_i,
    output mem_wb_t q_o
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) q_o <= '0;
        else       q_o <= d_i;
    end

endmodule

// File: rtl/pipe_mem.sv
// pipe_mem: EX/MEM register, word-addressed data memory and MEM/WB hand-off.
module pipe_mem
    import pipe_mem_pkg::*;
#(
    parameter int DMEM_AW    = DEF_DMEM_AW,
    parameter int DMEM_DEPTH = DEF_DMEM_DEPTH
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        EXwreg,
    input  logic        EXm2reg,
    input  logic        EXwmem,
    input  logic [4:0]  EXwn,
    input  logic [31:0] EXaluResult,
    input  logic [31:0] EXdi,
    output logic        MEMwreg,
    output logic [4:0]  MEMwn,
    output logic [31:0] MEMaluResult,
    output logic        MEMaddrErr,
    output logic        WBwreg,
    output logic        WBm2reg,
    output logic [4:0]  WBwn,
    output logic [31:0] WBaluResult,
    output logic [31:0] WBmo
);

    ex_mem_t             ex_mem_d, ex_mem_q;
    mem_wb_t             mem_wb_d, mem_wb_q;
    logic [31:0]         dmem [DMEM_DEPTH];
    logic [DMEM_AW-1:0]  idx;
    logic                we;

    assign ex_mem_d = '{wreg: EXwreg, m2reg: EXm2reg, wmem: EXwmem,
                        wn: EXwn, alu: EXaluResult, di: EXdi};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) ex_mem_q <= '0;
        else       ex_mem_q <= ex_mem_d;
    end

    assign idx        = ex_mem_q.alu[DMEM_AW+WORD_OFS-1:WORD_OFS];
    assign MEMaddrErr = (ex_mem_q.wmem | ex_mem_q.m2reg) & (|ex_mem_q.alu[WORD_OFS-1:0]);
    // reset zeroes wmem asynchronously, so an in-flight store is dropped without extra gating
    assign we         = ex_mem_q.wmem & ~MEMaddrErr;

    always_ff @(posedge clk) begin
        if (we) dmem[idx] <= ex_mem_q.di;
    end

    assign mem_wb_d = '{wreg: ex_mem_q.wreg & ~MEMaddrErr, m2reg: ex_mem_q.m2reg,
                        wn: ex_mem_q.wn, alu: ex_mem_q.alu, mo: dmem[idx]};

    MEM_WB_reg u_mem_wb (
        .clk  (clk),
        .clrn (clrn),
        .d_i  (mem_wb_d),
        .q_o  (mem_wb_q)
    );

    assign MEMwreg      = ex_mem_q.wreg;
    assign MEMwn        = ex_mem_q.wn;
    assign MEMaluResult = ex_mem_q.alu;
    assign WBwreg       = mem_wb_q.wreg;
    assign WBm2reg      = mem_wb_q.m2reg;
    assign WBwn         = mem_wb_q.wn;
    assign WBaluResult  = mem_wb_q.alu;
    assign WBmo         = mem_wb_q.mo;

endmodule

// File: tb/tb_pipe_mem.sv
// tb_pipe_mem: directed checks of pipe_mem latency, memory access, alignment and reset.
module tb_pipe_mem;

    logic        clk = 1'b0;
    logic        clrn;
    logic        EXwreg, EXm2reg, EXwmem;
    logic [4:0]  EXwn;
    logic [31:0] EXaluResult, EXdi;
    logic        MEMwreg, MEMaddrErr, WBwreg, WBm2reg;
    logic [4:0]  MEMwn, WBwn;
    logic [31:0] MEMaluResult, WBaluResult, WBmo;
    int          tests = 0;
    int          fails = 0;

    pipe_mem dut (
        .clk          (clk),
        .clrn         (clrn),
        .EXwreg       (EXwreg),
        .EXm2reg      (EXm2reg),
        .EXwmem       (EXwmem),
        .EXwn         (EXwn),
        .EXaluResult  (EXaluResult),
        .EXdi         (EXdi),
        .MEMwreg      (MEMwreg),
        .MEMwn        (MEMwn),
        .MEMaluResult (MEMaluResult),
        .MEMaddrErr   (MEMaddrErr),
        .WBwreg       (WBwreg),
        .WBm2reg      (WBm2reg),
        .WBwn         (WBwn),
        .WBaluResult  (WBaluResult),
        .WBmo         (WBmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one EX word, then step past the next rising edge
    task automatic ex(input logic wreg, input logic m2reg, input logic wmem,
                      input logic [4:0] wn, input logic [31:0] alu, input logic [31:0] di);
        EXwreg = wreg; EXm2reg = m2reg; EXwmem = wmem;
        EXwn = wn; EXaluResult = alu; EXdi = di;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        ex(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        clrn = 1'b0;
        EXwreg = 1'b1; EXm2reg = 1'b1; EXwmem = 1'b1;
        EXwn = 5'd31; EXaluResult = 32'hFFFF_FFFF; EXdi = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_MEMwreg", 32'(MEMwreg), 32'h0);
        chk("rst_MEMwn", 32'(MEMwn), 32'h0);
        chk("rst_MEMalu", MEMaluResult, 32'h0);
        chk("rst_MEMaddrErr", 32'(MEMaddrErr), 32'h0);
        chk("rst_WBwreg", 32'(WBwreg), 32'h0);
        chk("rst_WBm2reg", 32'(WBm2reg), 32'h0);
        chk("rst_WBwn", 32'(WBwn), 32'h0);
        chk("rst_WBalu", WBaluResult, 32'h0);
        chk("rst_WBmo", WBmo, 32'h0);
        clrn = 1'b1;

        ex(1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0);
        chk("alu_MEMwreg", 32'(MEMwreg), 32'h1);
        chk("alu_MEMwn", 32'(MEMwn), 32'd5);
        chk("alu_MEMalu", MEMaluResult, 32'h1234);
        chk("alu_MEMaddrErr", 32'(MEMaddrErr), 32'h0);
        bubble();
        chk("alu_WBalu", WBaluResult, 32'h1234);
        chk("alu_WBwreg", 32'(WBwreg), 32'h1);
        chk("alu_WBwn", 32'(WBwn), 32'd5);
        chk("alu_WBm2reg", 32'(WBm2reg), 32'h0);
        chk("bubble_MEMwreg", 32'(MEMwreg), 32'h0);

        ex(1'b0, 1'b0, 1'b1, 5'd0, 32'h10, 32'hDEAD_BEEF);
        ex(1'b1, 1'b1, 1'b0, 5'd7, 32'h10, 32'h0);
        bubble();
        chk("ld10_WBmo", WBmo, 32'hDEAD_BEEF);
        chk("ld10_WBm2reg", 32'(WBm2reg), 32'h1);
        chk("ld10_WBwn", 32'(WBwn), 32'd7);
        chk("ld10_WBwreg", 32'(WBwreg), 32'h1);

        ex(1'b0, 1'b0, 1'b1, 5'd0, 32'h13, 32'h1111_1111);
        chk("st13_addrErr", 32'(MEMaddrErr), 32'h1);
        bubble();
        chk("bubble_addrErr", 32'(MEMaddrErr), 32'h0);
        ex(1'b1, 1'b1, 1'b0, 5'd3, 32'h10, 32'h0);
        bubble();
        chk("word4_unchanged", WBmo, 32'hDEAD_BEEF);
        ex(1'b1, 1'b1, 1'b0, 5'd9, 32'h02, 32'h0);
        chk("ld02_addrErr", 32'(MEMaddrErr), 32'h1);
        bubble();
        chk("ld02_WBwreg", 32'(WBwreg), 32'h0);
        chk("ld02_WBwn", 32'(WBwn), 32'd9);

        ex(1'b0, 1'b0, 1'b1, 5'd0, 32'h100, 32'hA5A5_A5A5);
        ex(1'b1, 1'b1, 1'b0, 5'd1, 32'h0, 32'h0);
        bubble();
        chk("wrap_WBmo", WBmo, 32'hA5A5_A5A5);

        ex(1'b0, 1'b0, 1'b1, 5'd0, 32'h8, 32'h1);
        ex(1'b0, 1'b0, 1'b1, 5'd0, 32'hC, 32'h2);
        ex(1'b1, 1'b1, 1'b0, 5'd2, 32'h8, 32'h0);
        ex(1'b1, 1'b1, 1'b0, 5'd3, 32'hC, 32'h0);
        chk("b2b_ld8", WBmo, 32'h1);
        bubble();
        chk("b2b_ldC", WBmo, 32'h2);

        ex(1'b0, 1'b1, 1'b1, 5'd4, 32'h20, 32'h55AA_55AA);
        bubble();
        chk("stld_WBm2reg", 32'(WBm2reg), 32'h1);
        ex(1'b1, 1'b1, 1'b0, 5'd4, 32'h20, 32'h0);
        bubble();
        chk("stld_stored", WBmo, 32'h55AA_55AA);

        ex(1'b0, 1'b0, 1'b1, 5'd0, 32'h20, 32'hBADB_AD00);
        chk("inflight_MEMalu", MEMaluResult, 32'h20);
        #3;
        clrn = 1'b0;
        #1;
        chk("arst_MEMalu", MEMaluResult, 32'h0);
        chk("arst_MEMaddrErr", 32'(MEMaddrErr), 32'h0);
        chk("arst_WBalu", WBaluResult, 32'h0);
        chk("arst_WBwn", 32'(WBwn), 32'h0);
        chk("arst_WBm2reg", 32'(WBm2reg), 32'h0);
        @(posedge clk);
        #2;
        clrn = 1'b1;
        ex(1'b1, 1'b1, 1'b0, 5'd6, 32'h20, 32'h0);
        chk("post_rst_MEMwn", 32'(MEMwn), 32'd6);
        bubble();
        chk("discarded_store", WBmo, 32'h55AA_55AA);
        chk("post_rst_WBwn", 32'(WBwn), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
